// File: rtl/i2s_tx_sched_pkg.sv
// Shared types for the I2S transmit scheduler: channel-mode codes, FSM
// states and the per-slot source selection helper.
package i2s_tx_sched_pkg;

    localparam int I2S_DATA_WIDTH = 32;

    // Channel mode as driven on chm_i
    typedef enum logic [1:0] {
        I2S_CHM_STEREO = 2'b00,
        I2S_CHM_MONO_L = 2'b01,
        I2S_CHM_MONO_R = 2'b10,
        I2S_CHM_DUP    = 2'b11
    } chm_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_FETCH     = 3'd2,
        ST_PRESENT   = 3'd3,
        ST_WAIT_EDGE = 3'd4
    } state_e;

    // Where the sample for a slot comes from
    typedef enum logic [1:0] {
        SRC_L    = 2'd0,
        SRC_R    = 2'd1,
        SRC_ZERO = 2'd2,
        SRC_HOLD = 2'd3
    } src_e;

    // Slot 0 is left, slot 1 is right
    function automatic src_e src_sel(chm_e mode, logic slot);
        src_e s;
        case (mode)
            I2S_CHM_STEREO: s = slot ? SRC_R    : SRC_L;
            I2S_CHM_MONO_L: s = slot ? SRC_ZERO : SRC_L;
            I2S_CHM_MONO_R: s = slot ? SRC_R    : SRC_ZERO;
            default:        s = slot ? SRC_HOLD : SRC_L;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/i2s_tx_sched_ws_sync.sv
// WS synchronizer: two flops into the clk domain plus one history flop.
// Edge pulses are decoded from registers only, so they carry no
// combinational path from the pin.
module i2s_tx_sched_ws_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ws_i,
    output logic fall_o,
    output logic edge_o
);

    // [0],[1] synchronizer, [2] previous synchronized value
    logic [2:0] ws_pipe;

    // Shift the raw WS line through the synchronizer and history stage
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ws_pipe <= '0;
        else          ws_pipe <= {ws_pipe[1:0], ws_i};
    end

    assign fall_o = ~ws_pipe[1] &  ws_pipe[2];
    assign edge_o =  ws_pipe[1] ^  ws_pipe[2];

endmodule

// File: rtl/i2s_tx_sched.sv
// Left/right scheduler in front of the I2S core transmit port.
// Picks the source for each WS slot according to the channel mode,
// presents one sample per slot, substitutes zero and flags an underrun
// when a slot is missed.
// Optional underrun counter: define I2S_TX_SCHED_URUN_CNT_EN.
module i2s_tx_sched
    import i2s_tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH
`ifdef I2S_TX_SCHED_URUN_CNT_EN
    , parameter int URUN_CNT_W = 16
`endif
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic [1:0]            chm_i,
    input  logic                  i2s_ws_i,
    input  logic                  l_valid_i,
    output logic                  l_ready_o,
    input  logic [DATA_WIDTH-1:0] l_data_i,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    output logic                  slot_o,
    output logic                  busy_o,
    output logic                  urun_o
`ifdef I2S_TX_SCHED_URUN_CNT_EN
    ,
    output logic [URUN_CNT_W-1:0] urun_cnt_o,
    input  logic                  urun_clr_i
`endif
);

    state_e                state_q, state_d;
    chm_e                  mode_q, mode_d;
    logic                  slot_q, slot_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  urun_q, urun_d;
    logic                  tx_valid_q;

    logic                  ws_fall, ws_edge;
    src_e                  src;
    logic                  l_sel, r_sel, pop;
    logic [DATA_WIDTH-1:0] pop_data;

    i2s_tx_sched_ws_sync u_ws_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ws_i    (i2s_ws_i),
        .fall_o  (ws_fall),
        .edge_o  (ws_edge)
    );

    // Source ready: only in FETCH, only one source, and withdrawn on the
    // edge that turns a pending slot into an underrun.
    always_comb begin
        src      = src_sel(mode_q, slot_q);
        l_sel    = (state_q == ST_FETCH) && (src == SRC_L) && !(ws_edge && pend_q);
        r_sel    = (state_q == ST_FETCH) && (src == SRC_R) && !(ws_edge && pend_q);
        pop      = (l_sel && l_valid_i) || (r_sel && r_valid_i);
        pop_data = l_sel ? l_data_i : r_data_i;
    end

    assign l_ready_o = l_sel;
    assign r_ready_o = r_sel;

    // Slot FSM: next state, hold register, pending-edge and underrun logic
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        slot_d  = slot_q;
        pend_d  = pend_q;
        hold_d  = hold_q;
        urun_d  = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            hold_d  = '0;
            pend_d  = 1'b0;
            slot_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: begin
                    if (ws_fall) begin
                        mode_d  = chm_e'(chm_i);
                        slot_d  = 1'b0;
                        pend_d  = 1'b0;
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (pop) begin
                        // a pop beats a coincident edge, which is only remembered
                        hold_d  = pop_data;
                        pend_d  = pend_q | ws_edge;
                        state_d = ST_PRESENT;
                    end else if (ws_edge && pend_q) begin
                        urun_d  = 1'b1;
                        hold_d  = '0;
                        slot_d  = ~slot_q;
                    end else if (src == SRC_ZERO || src == SRC_HOLD) begin
                        if (src == SRC_ZERO) hold_d = '0;
                        pend_d  = pend_q | ws_edge;
                        state_d = ST_PRESENT;
                    end else begin
                        pend_d  = pend_q | ws_edge;
                    end
                end
                ST_PRESENT: begin
                    if (tx_ready_i) begin
                        pend_d  = pend_q | ws_edge;
                        state_d = ST_WAIT_EDGE;
                    end else if (ws_edge && pend_q) begin
                        urun_d  = 1'b1;
                        hold_d  = '0;
                        slot_d  = ~slot_q;
                        state_d = ST_FETCH;
                    end else begin
                        pend_d  = pend_q | ws_edge;
                    end
                end
                ST_WAIT_EDGE: begin
                    if (ws_edge || pend_q) begin
                        slot_d  = ~slot_q;
                        pend_d  = 1'b0;
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers; tx_valid is its own flop so the core
    // never sees a combinational path from any input.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= I2S_CHM_STEREO;
            slot_q     <= 1'b0;
            pend_q     <= 1'b0;
            hold_q     <= '0;
            urun_q     <= 1'b0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            slot_q     <= slot_d;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
            urun_q     <= urun_d;
            tx_valid_q <= (state_d == ST_PRESENT);
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = hold_q;
    assign slot_o     = slot_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign urun_o     = urun_q;

`ifdef I2S_TX_SCHED_URUN_CNT_EN
    logic [URUN_CNT_W-1:0] urun_cnt_q;

    // Saturating underrun counter; clear wins over a same-cycle increment
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                    urun_cnt_q <= '0;
        else if (urun_clr_i)             urun_cnt_q <= '0;
        else if (urun_q && !(&urun_cnt_q)) urun_cnt_q <= urun_cnt_q + 1'b1;
    end

    assign urun_cnt_o = urun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx_sched.sv
module tb_i2s_tx_sched;

    localparam int DW = 32;

    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, ws = 1'b0;
    logic [1:0]    chm = 2'b00;
    logic          l_valid = 1'b0, r_valid = 1'b0, tx_ready = 1'b0;
    logic [DW-1:0] l_data = '0, r_data = '0;
    logic          l_ready, r_ready, tx_valid, slot, busy, urun;
    logic [DW-1:0] tx_data;
`ifdef I2S_TX_SCHED_URUN_CNT_EN
    logic [15:0]   urun_cnt;
    logic          urun_clr = 1'b0;
`endif

    i2s_tx_sched dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .chm_i(chm), .i2s_ws_i(ws),
        .l_valid_i(l_valid), .l_ready_o(l_ready), .l_data_i(l_data),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_data_o(tx_data),
        .slot_o(slot), .busy_o(busy), .urun_o(urun)
`ifdef I2S_TX_SCHED_URUN_CNT_EN
        , .urun_cnt_o(urun_cnt), .urun_clr_i(urun_clr)
`endif
    );

    always #5 clk = ~clk;

    // Free-running WS: 16 clk per slot, changes just after a rising edge
    initial forever begin
        repeat (16) @(posedge clk);
        #1 ws = ~ws;
    end

    // Monitor: handshakes and ready sanity, sampled on the falling edge
    int            tx_n = 0, l_pops = 0, r_pops = 0, urun_n = 0;
    logic [DW-1:0] tx_log [512];
    logic          both_rdy = 1'b0, rdy_idle = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                tx_log[tx_n] <= tx_data;
                tx_n         <= tx_n + 1;
            end
            if (l_valid && l_ready) l_pops <= l_pops + 1;
            if (r_valid && r_ready) r_pops <= r_pops + 1;
            if (urun) urun_n <= urun_n + 1;
            if (l_ready && r_ready) both_rdy <= 1'b1;
            if ((l_ready || r_ready) && !busy) rdy_idle <= 1'b1;
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]    chm;
        logic [DW-1:0] l, r, exp_l, exp_r;
        int            lp, rp;
    } vec_t;

    vec_t vecs [4];
    int   t0, l0, r0, u0, cyc;
    logic [DW-1:0] seq [6];

    initial begin
        vecs[0] = '{2'b00, 32'h1111_0000, 32'h2222_0000, 32'h1111_0000, 32'h2222_0000, 4, 4};
        vecs[1] = '{2'b01, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h0000_0000, 4, 0};
        vecs[2] = '{2'b10, 32'h0BAD_0001, 32'h7777_8888, 32'h0000_0000, 32'h7777_8888, 0, 4};
        vecs[3] = '{2'b11, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 4, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst tx_valid", {31'd0, tx_valid}, 0);
        chk("rst tx_data",  tx_data, 0);
        chk("rst l_ready",  {31'd0, l_ready}, 0);
        chk("rst r_ready",  {31'd0, r_ready}, 0);
        chk("rst busy",     {31'd0, busy}, 0);
        chk("rst slot",     {31'd0, slot}, 0);
        chk("rst urun",     {31'd0, urun}, 0);
        rst_n = 1'b1;
        tx_ready = 1'b1;

        // Table: one run of 8 slots per channel mode
        for (int i = 0; i < 4; i++) begin
            chm = vecs[i].chm; l_data = vecs[i].l; r_data = vecs[i].r;
            l_valid = 1'b1; r_valid = 1'b1;
            @(posedge ws);
            t0 = tx_n; l0 = l_pops; r0 = r_pops; u0 = urun_n;
            en = 1'b1;
            repeat (8) @(ws);
            repeat (12) @(negedge clk);
            en = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d tx count", i), tx_n - t0, 8);
            for (int j = 0; j < 8; j++)
                chk($sformatf("v%0d slot%0d data", i, j), tx_log[t0 + j],
                    (j % 2 == 0) ? vecs[i].exp_l : vecs[i].exp_r);
            chk($sformatf("v%0d l pops", i), l_pops - l0, vecs[i].lp);
            chk($sformatf("v%0d r pops", i), r_pops - r0, vecs[i].rp);
            chk($sformatf("v%0d urun", i), urun_n - u0, 0);
        end

        // Stereo underrun: left source silent across two WS edges
        chm = 2'b00; l_data = 32'h1111_0000; r_data = 32'h2222_0000;
        l_valid = 1'b0; r_valid = 1'b1;
        @(posedge ws);
        t0 = tx_n; l0 = l_pops; r0 = r_pops; u0 = urun_n;
        en = 1'b1;
        repeat (3) @(ws);
        repeat (12) @(negedge clk);
        l_valid = 1'b1;
        repeat (4) @(ws);
        repeat (12) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        seq = '{32'h2222_0000, 32'h1111_0000, 32'h2222_0000,
                32'h1111_0000, 32'h2222_0000, 32'h1111_0000};
        chk("urun once", urun_n - u0, 1);
        chk("urun tx count", tx_n - t0, 6);
        for (int j = 0; j < 6; j++)
            chk($sformatf("urun seq%0d", j), tx_log[t0 + j], seq[j]);
        chk("urun l pops", l_pops - l0, 3);
        chk("urun r pops", r_pops - r0, 3);

        // Enable dropped while a sample is presented
        tx_ready = 1'b0;
        @(posedge ws);
        en = 1'b1;
        @(negedge ws);
        repeat (8) @(negedge clk);
        chk("hold tx_valid", {31'd0, tx_valid}, 1);
        chk("hold tx_data", tx_data, 32'h1111_0000);
        en = 1'b0;
        @(negedge clk);
        chk("dis tx_valid", {31'd0, tx_valid}, 0);
        chk("dis busy", {31'd0, busy}, 0);
        chk("dis tx_data", tx_data, 0);
        l0 = l_pops; t0 = tx_n;
        tx_ready = 1'b1;
        en = 1'b1;
        @(posedge ws);
        repeat (6) @(negedge clk);
        chk("reen no pop before fall", l_pops - l0, 0);
        @(negedge ws);
        repeat (12) @(negedge clk);
        chk("reen pop after fall", l_pops - l0, 1);
        chk("reen tx", tx_log[t0], 32'h1111_0000);
        en = 1'b0;
        @(negedge clk);

`ifdef I2S_TX_SCHED_URUN_CNT_EN
        // Underrun counter: three underruns, then clear racing an increment
        urun_clr = 1'b1;
        @(negedge clk);
        urun_clr = 1'b0;
        l_valid = 1'b0;
        @(posedge ws);
        u0 = urun_n;
        en = 1'b1;
        cyc = 0;
        while ((urun_n - u0) < 3 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("cnt 3 underruns seen", {31'd0, (urun_n - u0) >= 3}, 1);
        repeat (2) @(negedge clk);
        chk("urun_cnt 3", {16'd0, urun_cnt}, 3);
        cyc = 0;
        while (!urun && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("4th urun seen", {31'd0, urun}, 1);
        urun_clr = 1'b1;
        @(negedge clk);
        urun_clr = 1'b0;
        chk("clr beats inc", {16'd0, urun_cnt}, 0);
        en = 1'b0;
        l_valid = 1'b1;
        @(negedge clk);
`endif

        chk("ready both high", {31'd0, both_rdy}, 0);
        chk("ready while idle", {31'd0, rdy_idle}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
